regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised successor to the CPU register file. It provides a 2-read/1-write register array with configurable width and depth, an optional hardwired zero register and optional write-back forwarding. It adds a per-register pending-write scoreboard with an issue handshake, so decode can detect RAW hazards and reject WAW issues. It sits between decode/issue (read and issue ports) and write-back (write port).

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, address width; depth = 2**ADDR_W
ZERO_REG, 1, 1: register 0 reads as 0, writes and issues to it are ignored
FORWARD, 1, 1: same-cycle write-back data is bypassed to the read ports

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
rs1_addr  in  ADDR_W  read port 1 address
rs2_addr  in  ADDR_W  read port 2 address
rs1_data  out  DATA_W  read port 1 data (combinational)
rs2_data  out  DATA_W  read port 2 data (combinational)
rs1_busy  out  1  read port 1 register has a pending write
rs2_busy  out  1  read port 2 register has a pending write
iss_valid  in  1  issue request: mark iss_rd as pending
iss_rd  in  ADDR_W  destination register of the issued instruction
iss_ready  out  1  issue can be accepted this cycle
wb_en  in  1  write-back enable
wb_addr  in  ADDR_W  write-back address
wb_data  in  DATA_W  write-back data
flush  in  1  synchronous clear of all pending bits
pend_cnt  out  ADDR_W+1  number of registers currently pending

Behaviour:
- Reset (rst=0, asynchronous): all registers cleared to 0, all busy bits cleared to 0, pend_cnt=0.
  - The combinational outputs then give rs*_data=0, rs*_busy=0 and iss_ready=1.
  - Releasing rst takes effect on the next clk edge.
- Write: on posedge clk with wb_en=1, regs[wb_addr] <= wb_data.
  - With ZERO_REG=1, writes to address 0 are dropped.
  - A write is performed whether or not the register is busy.
- Read, raw value: regs[rs_addr], or 0 when ZERO_REG=1 and rs_addr=0.
- Read, forwarding (FORWARD=1): when wb_en=1, wb_addr==rs_addr and the write is not dropped, rs_data=wb_data. Otherwise rs_data is the raw value.
- Busy output: rs_busy = busy[rs_addr], with these exceptions:
  - forced 0 for address 0 when ZERO_REG=1;
  - with FORWARD=1, also forced 0 when a non-dropped write-back to that address is active this cycle.
  - A same-cycle issue never affects rs_busy in that cycle.
- Issue handshake:
  - iss_ready = ~busy[iss_rd], or 1 when a non-dropped write-back to iss_rd is active this cycle.
  - An issue is accepted when iss_valid & iss_ready & ~flush.
  - An accepted issue sets busy[iss_rd] at the clock edge.
  - Issue to address 0 with ZERO_REG=1: accepted (iss_ready=1) but sets nothing.
- Write-back clear: a non-dropped write-back clears busy[wb_addr] at the clock edge.
- Simultaneous issue and write-back:
  - Same register: the issue wins, busy stays 1, the data is written, pend_cnt is unchanged.
  - Different registers: both take effect.
- Flush:
  - At the clock edge all busy bits become 0 and pend_cnt becomes 0.
  - A same-cycle issue is dropped; a same-cycle write-back still writes data.
  - Register contents are untouched.
- pend_cnt:
  - Registered and equal to the popcount of the busy bits.
  - Per edge: +1 for an accepted issue that sets a new bit, -1 for a write-back that clears a set bit, net 0 when both happen.
  - Maximum value is 2**ADDR_W - ZERO_REG; it never wraps.
- Write-back to a non-busy register: data is written, busy and pend_cnt are unchanged.
- All state updates take exactly one clock edge. Reads have zero-cycle latency.

Test Plan:
- Reset: hold rst=0 with random inputs -> all rs*_data=0, rs*_busy=0, pend_cnt=0, iss_ready=1. Release rst, then read R5 -> 0x0000.
- Write/read and zero register: wb R3=0xBEEF, next cycle read rs1=3 -> 0xBEEF. wb R0=0x1234, read rs2=0 -> 0x0000.
- Forwarding: R7=0x0001 stored; same cycle wb R7=0xA5A5 and rs1=7 -> rs1_data=0xA5A5, rs1_busy=0. With FORWARD=0 -> 0x0001.
- Scoreboard:
  - issue R4 -> next cycle rs1=4 gives busy=1, pend_cnt=1.
  - Second issue to R4 -> iss_ready=0, pend_cnt stays 1.
  - wb R4=0x00FF -> next cycle busy=0, pend_cnt=0, data 0x00FF.
- Simultaneous events:
  - R2 busy; issue R2 and wb R2=0x5555 in the same cycle -> busy[2]=1, pend_cnt=1, regs[2]=0x5555.
  - Issue R6 and wb R2 in the same cycle -> pend_cnt=1, busy[6]=1, busy[2]=0.
- Flush and mid-run reset:
  - Issue R1, R2, R3 (pend_cnt=3); flush with issue R9 in the same cycle -> pend_cnt=0, busy[9]=0, register data kept.
  - Assert rst mid-sequence -> immediately all outputs are at their reset values.
  - Parameter sweep DATA_W=32, ADDR_W=5: fill all 31 registers with pending writes -> pend_cnt=31.

Source files
------------

// File: rtl/regfile_sb.sv
// Two-read / one-write register file with a per-register pending-write scoreboard.
// Decode reads operands and busy flags. Issue marks destinations pending. Write-back stores data and retires pending bits.
module regfile_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1,
  parameter int FORWARD  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              iss_ready,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH - ZERO_REG);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [CNT_W-1:0]  cnt;

  logic wb_live;
  logic iss_zero;
  logic iss_hit_wb;
  logic iss_set;
  logic cnt_inc;
  logic cnt_dec;
  logic rs1_fwd;
  logic rs2_fwd;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Saturating step so the count can never wrap even on an inconsistent update.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c,
                                                input logic up, input logic dn);
    if (up && !dn) return (c == CNT_MAX) ? c : c + CNT_W'(1);
    if (dn && !up) return (c == '0) ? c : c - CNT_W'(1);
    return c;
  endfunction

  assign wb_live = wb_en & ~is_zero(wb_addr);

  assign rs1_fwd = (FORWARD != 0) && wb_live && (wb_addr == rs1_addr);
  assign rs2_fwd = (FORWARD != 0) && wb_live && (wb_addr == rs2_addr);

  assign rs1_data = rs1_fwd ? wb_data : (is_zero(rs1_addr) ? '0 : regs[rs1_addr]);
  assign rs2_data = rs2_fwd ? wb_data : (is_zero(rs2_addr) ? '0 : regs[rs2_addr]);
  assign rs1_busy = ~is_zero(rs1_addr) & ~rs1_fwd & busy[rs1_addr];
  assign rs2_busy = ~is_zero(rs2_addr) & ~rs2_fwd & busy[rs2_addr];

  // A retiring write-back to the same destination frees the slot in the same cycle.
  assign iss_zero   = is_zero(iss_rd);
  assign iss_hit_wb = wb_live && (wb_addr == iss_rd);
  assign iss_ready  = iss_zero | ~busy[iss_rd] | iss_hit_wb;
  assign iss_set    = iss_valid & iss_ready & ~flush & ~iss_zero;

  // Same-register issue and retire cancel out: the bit stays set, count is unchanged.
  assign cnt_inc = iss_set & ~busy[iss_rd];
  assign cnt_dec = wb_live & busy[wb_addr] & ~(iss_set & iss_hit_wb);

  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wb_live) busy_nxt[wb_addr] = 1'b0;
      if (iss_set) busy_nxt[iss_rd]  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
      cnt  <= '0;
    end else begin
      busy <= busy_nxt;
      cnt  <= flush ? '0 : cnt_step(cnt, cnt_inc, cnt_dec);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wb_live) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign pend_cnt = cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default build, a no-forwarding build sharing its inputs,
// and a 32-bit / 32-entry build for the full-scoreboard case.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rs1_addr, rs2_addr, iss_rd, wb_addr;
  logic [15:0] wb_data;
  logic        iss_valid, wb_en, flush;

  logic [15:0] rs1_data, rs2_data, n_rs1_data, n_rs2_data;
  logic        rs1_busy, rs2_busy, iss_ready, n_rs1_busy, n_rs2_busy, n_iss_ready;
  logic [4:0]  pend_cnt, n_pend_cnt;

  logic [4:0]  w_rs1_addr, w_rs2_addr, w_iss_rd, w_wb_addr;
  logic [31:0] w_wb_data, w_rs1_data, w_rs2_data;
  logic        w_iss_valid, w_wb_en, w_flush, w_rs1_busy, w_rs2_busy, w_iss_ready;
  logic [5:0]  w_pend_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .pend_cnt(pend_cnt)
  );

  regfile_sb #(.FORWARD(0)) dut_nofwd (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(n_rs1_data), .rs2_data(n_rs2_data), .rs1_busy(n_rs1_busy), .rs2_busy(n_rs2_busy),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(n_iss_ready),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .pend_cnt(n_pend_cnt)
  );

  regfile_sb #(.DATA_W(32), .ADDR_W(5)) dut_wide (
    .clk(clk), .rst(rst), .rs1_addr(w_rs1_addr), .rs2_addr(w_rs2_addr),
    .rs1_data(w_rs1_data), .rs2_data(w_rs2_data), .rs1_busy(w_rs1_busy), .rs2_busy(w_rs2_busy),
    .iss_valid(w_iss_valid), .iss_rd(w_iss_rd), .iss_ready(w_iss_ready),
    .wb_en(w_wb_en), .wb_addr(w_wb_addr), .wb_data(w_wb_data), .flush(w_flush),
    .pend_cnt(w_pend_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rs1_addr = '0; rs2_addr = '0; iss_valid = 1'b0; iss_rd = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0;
    w_rs1_addr = '0; w_rs2_addr = '0; w_iss_valid = 1'b0; w_iss_rd = '0;
    w_wb_en = 1'b0; w_wb_addr = '0; w_wb_data = '0; w_flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #2 rst = 1'b0;

    // reset held with random inputs (no write-back, so nothing is forwarded)
    for (int i = 0; i < 4; i++) begin
      tick();
      rs1_addr = 4'($urandom); rs2_addr = 4'($urandom); iss_rd = 4'($urandom);
      iss_valid = 1'($urandom); flush = 1'($urandom); wb_addr = 4'($urandom);
      wb_data = 16'($urandom); wb_en = 1'b0;
      #1;
      check("rst_rs1_data", rs1_data, 0);
      check("rst_rs2_data", rs2_data, 0);
      check("rst_rs1_busy", rs1_busy, 0);
      check("rst_rs2_busy", rs2_busy, 0);
      check("rst_pend", pend_cnt, 0);
      check("rst_iss_ready", iss_ready, 1);
      check("rst_wide_pend", w_pend_cnt, 0);
    end
    idle();
    rst = 1'b1;
    tick();
    rs1_addr = 4'd5; #1;
    check("post_rst_r5", rs1_data, 16'h0000);

    // write / read and zero register
    idle(); wb_en = 1; wb_addr = 4'd3; wb_data = 16'hBEEF;
    tick(); idle(); rs1_addr = 4'd3; #1;
    check("wr_r3", rs1_data, 16'hBEEF);
    wb_en = 1; wb_addr = 4'd0; wb_data = 16'h1234; rs2_addr = 4'd0; #1;
    check("r0_fwd_dropped", rs2_data, 16'h0000);
    tick(); idle(); rs2_addr = 4'd0; #1;
    check("r0_read", rs2_data, 16'h0000);

    // forwarding
    wb_en = 1; wb_addr = 4'd7; wb_data = 16'h0001;
    tick(); idle(); wb_en = 1; wb_addr = 4'd7; wb_data = 16'hA5A5; rs1_addr = 4'd7; #1;
    check("fwd_data", rs1_data, 16'hA5A5);
    check("fwd_busy", rs1_busy, 0);
    check("nofwd_data", n_rs1_data, 16'h0001);
    tick(); idle(); rs1_addr = 4'd7; #1;
    check("fwd_stored", rs1_data, 16'hA5A5);
    check("nofwd_stored", n_rs1_data, 16'hA5A5);

    // scoreboard issue / reject / retire
    idle(); iss_valid = 1; iss_rd = 4'd4; #1;
    check("iss4_ready", iss_ready, 1);
    tick(); idle(); rs1_addr = 4'd4; iss_valid = 1; iss_rd = 4'd4; #1;
    check("r4_busy", rs1_busy, 1);
    check("r4_pend", pend_cnt, 1);
    check("r4_waw_ready", iss_ready, 0);
    tick(); idle(); #1;
    check("r4_waw_pend", pend_cnt, 1);
    wb_en = 1; wb_addr = 4'd4; wb_data = 16'h00FF; rs1_addr = 4'd4; #1;
    check("r4_wb_busy_fwd", rs1_busy, 0);
    check("r4_wb_busy_nofwd", n_rs1_busy, 1);
    tick(); idle(); rs1_addr = 4'd4; #1;
    check("r4_ret_busy", rs1_busy, 0);
    check("r4_ret_pend", pend_cnt, 0);
    check("r4_ret_data", rs1_data, 16'h00FF);

    // simultaneous issue and write-back
    iss_valid = 1; iss_rd = 4'd2;
    tick(); idle(); iss_valid = 1; iss_rd = 4'd2; wb_en = 1; wb_addr = 4'd2; wb_data = 16'h5555; #1;
    check("same_ready", iss_ready, 1);
    check("same_pend_pre", pend_cnt, 1);
    tick(); idle(); rs1_addr = 4'd2; #1;
    check("same_busy", rs1_busy, 1);
    check("same_pend", pend_cnt, 1);
    check("same_data", rs1_data, 16'h5555);
    iss_valid = 1; iss_rd = 4'd6; wb_en = 1; wb_addr = 4'd2; wb_data = 16'h1111;
    tick(); idle(); rs1_addr = 4'd6; rs2_addr = 4'd2; #1;
    check("diff_busy6", rs1_busy, 1);
    check("diff_busy2", rs2_busy, 0);
    check("diff_pend", pend_cnt, 1);
    check("diff_data2", rs2_data, 16'h1111);
    wb_en = 1; wb_addr = 4'd6; wb_data = 16'h6666;
    tick(); idle(); #1;
    check("r6_ret_pend", pend_cnt, 0);

    // flush
    for (int r = 1; r <= 3; r++) begin
      iss_valid = 1; iss_rd = 4'(r);
      tick(); idle();
    end
    #1;
    check("three_pend", pend_cnt, 3);
    flush = 1; iss_valid = 1; iss_rd = 4'd9; wb_en = 1; wb_addr = 4'd10; wb_data = 16'hAAAA; #1;
    check("flush_iss_ready", iss_ready, 1);
    tick(); idle(); rs1_addr = 4'd9; rs2_addr = 4'd3; #1;
    check("flush_pend", pend_cnt, 0);
    check("flush_busy9", rs1_busy, 0);
    check("flush_busy3", rs2_busy, 0);
    check("flush_keep_r3", rs2_data, 16'hBEEF);
    rs1_addr = 4'd10; #1;
    check("flush_wb_r10", rs1_data, 16'hAAAA);

    // issue to zero register
    idle(); iss_valid = 1; iss_rd = 4'd0; #1;
    check("r0_iss_ready", iss_ready, 1);
    tick(); idle(); #1;
    check("r0_iss_pend", pend_cnt, 0);

    // mid-run asynchronous reset
    iss_valid = 1; iss_rd = 4'd5; wb_en = 1; wb_addr = 4'd8; wb_data = 16'h8888;
    tick(); idle(); rs1_addr = 4'd8; rs2_addr = 4'd5; iss_rd = 4'd5; #1;
    check("pre_rst_data", rs1_data, 16'h8888);
    check("pre_rst_busy", rs2_busy, 1);
    check("pre_rst_ready", iss_ready, 0);
    rst = 1'b0; #1;
    check("mid_rst_data", rs1_data, 0);
    check("mid_rst_busy", rs2_busy, 0);
    check("mid_rst_pend", pend_cnt, 0);
    check("mid_rst_ready", iss_ready, 1);
    rst = 1'b1;
    tick(); idle();

    // wide build: fill every writable register with a pending write
    for (int r = 0; r < 32; r++) begin
      w_iss_valid = 1; w_iss_rd = 5'(r);
      tick();
    end
    idle(); w_rs1_addr = 5'd31; w_iss_valid = 1; w_iss_rd = 5'd5; #1;
    check("wide_pend_full", w_pend_cnt, 31);
    check("wide_busy31", w_rs1_busy, 1);
    check("wide_waw_ready", w_iss_ready, 0);
    idle(); w_wb_en = 1; w_wb_addr = 5'd31; w_wb_data = 32'hDEADBEEF;
    tick(); idle(); w_rs1_addr = 5'd31; #1;
    check("wide_data31", w_rs1_data, 32'hDEADBEEF);
    check("wide_pend_after", w_pend_cnt, 30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
